// File: rtl/exec_arith_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_arith_unit_pkg
// Description : Shared encodings for the 8-bit single-cycle CPU datapath.
//               ALU operation codes (ALUOP) and shift/rotate mode codes
//               (OPERAND2[7:6] when ALUOP selects the shifter). Imported by
//               the arithmetic unit and by the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_arith_unit_pkg;

  // ALU operation select
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;

  // Shift/rotate mode carried in OPERAND2[7:6]
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/exec_arith_unit_alu8.sv
`default_nettype none
// ============================================================================
// Module      : exec_arith_unit_alu8
// Description : Purely combinational 8-bit ALU.
// Ports       : DATA1    in  8  first operand
//               OPERAND2 in  8  second operand (already muxed by the caller)
//               ALUOP    in  3  operation select (ALU_* codes)
//               RESULT   out 8  ALU result
//               ZERO     out 1  RESULT == 0
// Revision    : 1.0 - initial release
// ============================================================================
module exec_arith_unit_alu8
  import exec_arith_unit_pkg::*;
(
  input  logic [7:0] DATA1,
  input  logic [7:0] OPERAND2,
  input  logic [2:0] ALUOP,
  output logic [7:0] RESULT,
  output logic       ZERO
);

  logic [15:0]       w_prod;
  logic [3:0]        w_amt;
  logic [2:0]        w_sh;
  logic              w_big;
  logic signed [7:0] w_sra_src;
  logic signed [7:0] w_sra;
  logic [15:0]       w_rot;
  logic [7:0]        w_shift;
  logic [7:0]        w_result;

  // Zero-extend both operands so the product keeps its full 16 bits.
  assign w_prod = {8'h00, DATA1} * {8'h00, OPERAND2};

  // Amount is OPERAND2[3:0]; bit 3 set means the shift is 8 or more.
  assign w_amt     = OPERAND2[3:0];
  assign w_sh      = w_amt[2:0];
  assign w_big     = w_amt[3];
  assign w_sra_src = DATA1;
  assign w_sra     = w_sra_src >>> w_sh;
  // Rotation by amount mod 8: shift a doubled copy and keep the low byte.
  assign w_rot     = {DATA1, DATA1} >> w_sh;

  always_comb begin
    w_shift = DATA1;
    case (OPERAND2[7:6])
      SH_SLL:  w_shift = w_big ? 8'h00 : (DATA1 << w_sh);
      SH_SRL:  w_shift = w_big ? 8'h00 : (DATA1 >> w_sh);
      SH_SRA:  w_shift = w_big ? {8{DATA1[7]}} : w_sra;
      SH_ROR:  w_shift = w_rot[7:0];
      default: w_shift = DATA1;
    endcase
  end

  always_comb begin
    w_result = 8'h00;
    case (ALUOP)
      ALU_FWD: w_result = OPERAND2;
      ALU_ADD: w_result = DATA1 + OPERAND2;
      ALU_AND: w_result = DATA1 & OPERAND2;
      ALU_OR:  w_result = DATA1 | OPERAND2;
      ALU_MUL: w_result = w_prod[7:0];
      ALU_SHR: w_result = w_shift;
      default: w_result = 8'h00;
    endcase
  end

  assign RESULT = w_result;
  assign ZERO   = (w_result == 8'h00);

endmodule
`default_nettype wire

// File: rtl/exec_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_arith_unit
// Description : Arithmetic core of the 8-bit single-cycle CPU. Holds the
//               program counter and its +4 incrementer, forms the negated
//               second operand, selects operand 2 and runs the 8-bit ALU.
// Ports       : CLK       in  1   system clock, rising edge
//               RESET     in  1   synchronous active-high reset (PC only)
//               PC_NEXT   in  32  next PC from the flow-control mux
//               PC        out 32  current program counter
//               PC_INC    out 32  PC + 4
//               DATA1     in  8   register operand 1
//               DATA2     in  8   register operand 2
//               IMM       in  8   immediate field
//               NEG_SEL   in  1   use 2's complement of DATA2
//               IMM_SEL   in  1   use IMM (overrides NEG_SEL)
//               ALUOP     in  3   operation select
//               TWOS_COMP out 8   ~DATA2 + 1
//               RESULT    out 8   ALU result
//               ZERO      out 1   RESULT == 0
// Revision    : 1.0 - initial release
// ============================================================================
module exec_arith_unit
  import exec_arith_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC_NEXT,
  output logic [31:0] PC,
  output logic [31:0] PC_INC,
  input  logic [7:0]  DATA1,
  input  logic [7:0]  DATA2,
  input  logic [7:0]  IMM,
  input  logic        NEG_SEL,
  input  logic        IMM_SEL,
  input  logic [2:0]  ALUOP,
  output logic [7:0]  TWOS_COMP,
  output logic [7:0]  RESULT,
  output logic        ZERO
);

  logic [31:0] r_pc;
  logic [7:0]  w_twos;
  logic [7:0]  w_operand2;

  // The PC is the only state in the block; reset wins over PC_NEXT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc <= 32'h0000_0000;
    end else begin
      r_pc <= PC_NEXT;
    end
  end

  assign PC     = r_pc;
  assign PC_INC = r_pc + 32'd4;

  assign w_twos     = ~DATA2 + 8'd1;
  assign w_operand2 = IMM_SEL ? IMM : (NEG_SEL ? w_twos : DATA2);
  assign TWOS_COMP  = w_twos;

  exec_arith_unit_alu8 u_alu8 (
    .DATA1    (DATA1),
    .OPERAND2 (w_operand2),
    .ALUOP    (ALUOP),
    .RESULT   (RESULT),
    .ZERO     (ZERO)
  );

endmodule
`default_nettype wire

// File: tb/tb_exec_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_arith_unit
// Description : Self-checking bench for exec_arith_unit: directed cases plus
//               randomized operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_arith_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC_NEXT;
  logic [31:0] PC;
  logic [31:0] PC_INC;
  logic [7:0]  DATA1;
  logic [7:0]  DATA2;
  logic [7:0]  IMM;
  logic        NEG_SEL;
  logic        IMM_SEL;
  logic [2:0]  ALUOP;
  logic [7:0]  TWOS_COMP;
  logic [7:0]  RESULT;
  logic        ZERO;

  int n_checks = 0;
  int n_errors = 0;

  exec_arith_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PC_NEXT   (PC_NEXT),
    .PC        (PC),
    .PC_INC    (PC_INC),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .IMM       (IMM),
    .NEG_SEL   (NEG_SEL),
    .IMM_SEL   (IMM_SEL),
    .ALUOP     (ALUOP),
    .TWOS_COMP (TWOS_COMP),
    .RESULT    (RESULT),
    .ZERO      (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Shift/rotate reference built from repeated single-bit steps.
  function automatic int ref_shift(input int a, input int b);
    int mode = b / 64;
    int amt  = b % 16;
    int r    = a;
    case (mode)
      0: repeat (amt) r = (r * 2) % 256;
      1: repeat (amt) r = r / 2;
      2: repeat (amt) r = r / 2 + ((r >= 128) ? 128 : 0);
      default: repeat (amt % 8) r = r / 2 + (r % 2) * 128;
    endcase
    return r;
  endfunction

  function automatic int ref_op2(input int d2, input int imm, input bit neg, input bit isel);
    if (isel) return imm;
    if (neg)  return (256 - d2) % 256;
    return d2;
  endfunction

  function automatic int ref_result(input int d1, input int b, input int op);
    case (op)
      0: return b;
      1: return (d1 + b) % 256;
      2: return d1 & b;
      3: return d1 | b;
      4: return (d1 * b) % 256;
      5: return ref_shift(d1, b);
      default: return 0;
    endcase
  endfunction

  // Drive one ALU vector, let it settle, then compare against the model.
  task automatic run_alu(input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] imm,
                         input logic neg, input logic isel, input logic [2:0] op);
    int b;
    int r;
    DATA1 = d1; DATA2 = d2; IMM = imm; NEG_SEL = neg; IMM_SEL = isel; ALUOP = op;
    #1;
    b = ref_op2(int'(d2), int'(imm), neg, isel);
    r = ref_result(int'(d1), b, int'(op));
    check("twos_comp", {24'h0, TWOS_COMP}, 32'((256 - int'(d2)) % 256));
    check("result",    {24'h0, RESULT},    32'(r));
    check("zero",      {31'h0, ZERO},      {31'h0, (r == 0)});
  endtask

  task automatic clock_pc(input logic rst, input logic [31:0] nxt, input string tag);
    RESET = rst; PC_NEXT = nxt;
    @(posedge CLK);
    #1;
    check({tag, "_pc"},     PC,     rst ? 32'h0 : nxt);
    check({tag, "_pc_inc"}, PC_INC, rst ? 32'h4 : nxt + 32'd4);
  endtask

  initial begin
    RESET = 1'b1; PC_NEXT = 32'h40;
    DATA1 = 8'h00; DATA2 = 8'h00; IMM = 8'h00;
    NEG_SEL = 1'b0; IMM_SEL = 1'b0; ALUOP = 3'b000;

    // Reset then first load
    @(posedge CLK); #1;
    check("reset_pc",     PC,     32'h0);
    check("reset_pc_inc", PC_INC, 32'h4);
    RESET = 1'b0; PC_NEXT = 32'h8;
    @(posedge CLK); #1;
    check("load_pc",     PC,     32'h8);
    check("load_pc_inc", PC_INC, 32'hC);

    // beq/bne style subtract
    run_alu(8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 3'b001);
    check("sub_twos", {24'h0, TWOS_COMP}, 32'hFB);
    check("sub_eq",   {24'h0, RESULT},    32'h00);
    check("sub_zero", {31'h0, ZERO},      32'h1);
    run_alu(8'h07, 8'h05, 8'h00, 1'b1, 1'b0, 3'b001);
    check("sub_ne",   {24'h0, RESULT},    32'h02);
    check("sub_nz",   {31'h0, ZERO},      32'h0);

    // Two's complement corner values
    run_alu(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b000);
    check("twos_00", {24'h0, TWOS_COMP}, 32'h00);
    run_alu(8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 3'b000);
    check("twos_80", {24'h0, TWOS_COMP}, 32'h80);
    run_alu(8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 3'b000);
    check("twos_01", {24'h0, RESULT},    32'hFF);

    // Forward immediate (IMM_SEL overrides NEG_SEL), logic, add carry drop
    run_alu(8'h00, 8'h11, 8'h2A, 1'b1, 1'b1, 3'b000);
    check("fwd_imm", {24'h0, RESULT}, 32'h2A);
    run_alu(8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 3'b010);
    check("and",     {24'h0, RESULT}, 32'h30);
    run_alu(8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 3'b011);
    check("or",      {24'h0, RESULT}, 32'hFC);
    run_alu(8'hFF, 8'h02, 8'h00, 1'b0, 1'b0, 3'b001);
    check("add_wrap", {24'h0, RESULT}, 32'h01);

    // Multiply low byte
    run_alu(8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 3'b100);
    check("mul_hi", {24'h0, RESULT}, 32'h10);
    run_alu(8'h03, 8'h04, 8'h00, 1'b0, 1'b0, 3'b100);
    check("mul_lo", {24'h0, RESULT}, 32'h0C);

    // Shift/rotate table on DATA1 = 0x81
    begin
      logic [7:0] sh_imm [7] = '{8'h01, 8'h41, 8'h81, 8'hC1, 8'h09, 8'h89, 8'hC9};
      logic [7:0] sh_exp [7] = '{8'h02, 8'h40, 8'hC0, 8'hC0, 8'h00, 8'hFF, 8'hC0};
      for (int i = 0; i < 7; i++) begin
        run_alu(8'h81, 8'h00, sh_imm[i], 1'b0, 1'b1, 3'b101);
        check($sformatf("shift_%02h", sh_imm[i]), {24'h0, RESULT}, {24'h0, sh_exp[i]});
      end
      run_alu(8'h81, 8'h00, 8'h30, 1'b0, 1'b1, 3'b101);
      check("shift_amt0", {24'h0, RESULT}, 32'h81);
    end

    // Unused opcodes yield zero
    run_alu(8'hAB, 8'hCD, 8'h00, 1'b0, 1'b0, 3'b110);
    check("op110_zero", {31'h0, ZERO}, 32'h1);
    run_alu(8'hAB, 8'hCD, 8'h00, 1'b0, 1'b0, 3'b111);
    check("op111", {24'h0, RESULT}, 32'h00);

    // PC wrap and reset priority
    clock_pc(1'b0, 32'hFFFF_FFFC, "wrap");
    check("wrap_inc_zero", PC_INC, 32'h0);
    clock_pc(1'b1, 32'h0000_1234, "rst_mid");

    // RESET has no influence on combinational outputs
    RESET = 1'b1;
    run_alu(8'h07, 8'h05, 8'h00, 1'b1, 1'b0, 3'b001);
    RESET = 1'b0;

    // Randomized ALU vectors interleaved with random PC traffic
    for (int k = 0; k < 300; k++) begin
      logic [7:0] rd1, rd2, rimm;
      rd1  = 8'($urandom);
      rd2  = 8'($urandom);
      rimm = 8'($urandom);
      if ((k % 4) == 0) rd2 = 8'($urandom_range(0, 2)) * 8'h80;
      run_alu(rd1, rd2, rimm, 1'($urandom), 1'($urandom), 3'($urandom));
      if ((k % 10) == 0)
        clock_pc(($urandom_range(0, 7) == 0), $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_arith_unit.md
# exec_arith_unit

Arithmetic core of the 8-bit single-cycle CPU: holds the 32-bit program counter with its +4 incrementer, forms the 2's complement of the second register operand, selects register/negated/immediate operand, and runs the 8-bit ALU that produces the write-back value and the ZERO flag used by beq/bne. Instruction decode, register file and branch-target logic sit outside and drive this block's control inputs.

## Interface
- No parameters; widths fixed (data 8 bits, PC 32 bits).
- CLK  in  1  system clock, rising edge active.
- RESET  in  1  synchronous, active-high reset; sampled on rising CLK.
- PC_NEXT  in  32  next PC chosen by external flow-control mux.
- PC  out  32  current program counter (registered).
- PC_INC  out  32  PC + 4.
- DATA1  in  8  operand 1 (REGOUT1).
- DATA2  in  8  register operand 2 (REGOUT2).
- IMM  in  8  instruction bits [7:0].
- NEG_SEL  in  1  1 = use 2's complement of DATA2 (sub, beq, bne).
- IMM_SEL  in  1  1 = use IMM as operand 2 (overrides NEG_SEL).
- ALUOP  in  3  operation select.
- TWOS_COMP  out  8  ~DATA2 + 1.
- RESULT  out  8  ALU result.
- ZERO  out  1  RESULT == 8'h00.

## Operation
- TWOS_COMP = (~DATA2 + 1) mod 256; 0x00 -> 0x00, 0x80 -> 0x80, 0x01 -> 0xFF.
- OPERAND2 = IMM_SEL ? IMM : (NEG_SEL ? TWOS_COMP : DATA2).
- ALUOP 000 FORWARD: RESULT = OPERAND2.
- ALUOP 001 ADD: RESULT = (DATA1 + OPERAND2) mod 256, carry discarded.
- ALUOP 010 AND, 011 OR: bitwise.
- ALUOP 100 MULT: RESULT = low 8 bits of unsigned DATA1 * OPERAND2.
- ALUOP 101 SHIFT_ROTATE on DATA1, controlled by OPERAND2: bits [7:6] mode (00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right), bits [3:0] amount; bits [5:4] ignored. Amount >= 8: logical shifts give 0x00, arithmetic right gives all sign bits, rotate uses amount mod 8. Amount 0 returns DATA1.
- ALUOP 110, 111: RESULT = 0x00 (ZERO = 1).
- ZERO derived from RESULT for every op; beq/bne rely on it with NEG_SEL=1, ALUOP=ADD.
- PC_INC = (PC + 4) mod 2^32; 0xFFFFFFFC wraps to 0x00000000.

## Timing
- PC is the only state. Rising CLK: RESET=1 -> PC <= 0; else PC <= PC_NEXT. RESET has priority; asserted mid-program it zeroes PC at the next edge regardless of PC_NEXT.
- PC value after reset: 0x00000000; PC_INC = 0x00000004.
- PC_INC, TWOS_COMP, OPERAND2, RESULT, ZERO are purely combinational, settle within the same cycle; no pipeline latency, no handshake.
- No explicit # delays in RTL; combinational path must close within one CLK period together with external decode and register read.
- RESET does not affect combinational outputs.

## Structure
- Shared package: ALUOP constants (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_MUL, ALU_SHR) and shift-mode constants (SH_SLL, SH_SRL, SH_SRA, SH_ROR); imported by decode logic too.
- One sub-module natural: alu8 (DATA1, OPERAND2, ALUOP -> RESULT, ZERO). 2's complement, operand mux, PC adder and PC register stay inline in the top.

## Test plan
- RESET=1 for one edge with PC_NEXT=0x40 -> PC=0x0, PC_INC=0x4; release, PC_NEXT=0x8 -> PC=0x8 after next edge, PC_INC=0xC.
- DATA2=0x05, NEG_SEL=1, DATA1=0x05, ALUOP=ADD -> TWOS_COMP=0xFB, RESULT=0x00, ZERO=1; DATA1=0x07 -> RESULT=0x02, ZERO=0.
- IMM_SEL=1, IMM=0x2A, ALUOP=FWD -> RESULT=0x2A; DATA1=0xF0, DATA2=0x3C: AND -> 0x30, OR -> 0xFC; ADD 0xFF+0x02 -> 0x01.
- MULT DATA1=0x10, DATA2=0x11 -> RESULT=0x10; DATA1=0x03, DATA2=0x04 -> 0x0C.
- SHIFT_ROTATE DATA1=0x81, IMM_SEL=1: IMM=0x01 -> 0x02; 0x41 -> 0x40; 0x81 -> 0xC0; 0xC1 -> 0xC0; 0x09 -> 0x00; 0x89 -> 0xFF; 0xC9 -> 0xC0.
- PC wrap: PC_NEXT=0xFFFFFFFC loaded -> PC_INC=0x00000000; RESET asserted same edge as new PC_NEXT -> PC=0.
